// File: rtl/vga_fb_reader.sv
// vga_fb_reader
//   Scans a 640x480 @ 60 Hz VGA raster (800x525 total, pixel clock = clk/2)
//   and fetches a 256x256 RGB332 image from a framebuffer through a memory
//   read port with one-clk synchronous latency. The image occupies the
//   top-left corner of the active area; the rest of the active area is black.
//
// Ports
//   clk          system clock (50 MHz nominal)
//   reset        synchronous, active-high
//   vga_addr     framebuffer byte address for the current (h,v), combinational
//   vga_data     RGB332 pixel returned one clk after vga_addr
//   pix_en       pixel strobe, high every second clk
//   hsync/vsync  active-low sync pulses
//   blank_n      high only inside the 640x480 active area
//   vga_r/g/b    8-bit colour, RGB332 expanded by bit replication
//   frame_start  one-clk pulse after the raster wraps from (799,524) to (0,0)
`timescale 1ns/1ps
module vga_fb_reader #(
  parameter logic [31:0] FB_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] vga_addr,
  input  logic [7:0]  vga_data,
  output logic        pix_en,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] IMG_DIM  = 10'd256;

  // RGB332 -> RGB888 by replicating the high bits into the low bits, so that
  // full-scale codes map to 8'hFF and zero stays zero.
  function automatic logic [23:0] rgb332_expand(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6],
            d[4:2], d[4:2], d[4:3],
            d[1:0], d[1:0], d[1:0], d[1:0]};
  endfunction

  logic       pix_en_q, pix_en_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_n_q, blank_n_d;
  logic [7:0] r_q, r_d;
  logic [7:0] g_q, g_d;
  logic [7:0] b_q, b_d;
  logic       frame_q, frame_d;

  logic       h_wrap, v_wrap, active, in_img;
  logic [23:0] rgb;

  // The address follows the counters directly; the memory registers it on
  // the pix_en=0 edge, so the data is ready on the following pix_en=1 edge.
  assign vga_addr = FB_BASE + {16'h0000, v_q[7:0], h_q[7:0]};

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);
  assign active = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
  assign in_img = (h_q < IMG_DIM) && (v_q < IMG_DIM);
  assign rgb    = rgb332_expand(vga_data);

  always_comb begin
    pix_en_d  = ~pix_en_q;
    h_d       = h_q;
    v_d       = v_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    blank_n_d = blank_n_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    frame_d   = 1'b0;
    if (pix_en_q) begin
      // Capture the outputs for the current (h,v), then advance past it.
      hsync_d   = !((h_q >= H_SYNC_S) && (h_q <= H_SYNC_E));
      vsync_d   = !((v_q >= V_SYNC_S) && (v_q <= V_SYNC_E));
      blank_n_d = active;
      if (active && in_img) begin
        r_d = rgb[23:16];
        g_d = rgb[15:8];
        b_d = rgb[7:0];
      end else begin
        r_d = 8'h00;
        g_d = 8'h00;
        b_d = 8'h00;
      end
      frame_d = h_wrap && v_wrap;
      h_d     = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en_q  <= 1'b0;
      h_q       <= 10'd0;
      v_q       <= 10'd0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= 8'h00;
      g_q       <= 8'h00;
      b_q       <= 8'h00;
      frame_q   <= 1'b0;
    end else begin
      pix_en_q  <= pix_en_d;
      h_q       <= h_d;
      v_q       <= v_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_n_q <= blank_n_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      frame_q   <= frame_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader
//   Directed bench for vga_fb_reader. A small framebuffer model answers
//   reads one clk after the address; the raster position is jumped with
//   force/release so that far corners of the frame can be reached quickly.
`timescale 1ns/1ps
module tb_vga_fb_reader;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] vga_addr;
  logic [7:0]  vga_data;
  logic        pix_en, hsync, vsync, blank_n, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;

  logic        ff_all;
  logic [9:0]  fh, fv;
  int          nassert = 0;
  int          nfail   = 0;

  vga_fb_reader #(.FB_BASE(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .vga_addr    (vga_addr),
    .vga_data    (vga_data),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start)
  );

  always #10 clk = ~clk;

  // Framebuffer contents: two marked pixels, otherwise low^high address byte.
  function automatic logic [7:0] mem_model(input logic [31:0] addr, input logic all_ff);
    logic [31:0] off;
    off = addr - BASE;
    if (all_ff)                 return 8'hFF;
    if (off == 32'h0000_0305)   return 8'hE0;
    if (off == 32'h0000_FFFF)   return 8'h1F;
    return off[7:0] ^ off[15:8];
  endfunction

  always @(posedge clk) vga_data <= mem_model(vga_addr, ff_all);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next pix_en=1 edge.
  task automatic adv();
    int n = 0;
    while (pix_en !== 1'b1 && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pix_phase", {31'd0, pix_en}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic set_hv(input logic [9:0] h, input logic [9:0] v);
    fh = h;
    fv = v;
    force dut.h_q = fh;
    force dut.v_q = fv;
    #1;
    release dut.h_q;
    release dut.v_q;
    #1;
  endtask

  task automatic chk_rgb(input string tag, input logic [23:0] exp);
    chk(tag, {8'd0, vga_r, vga_g, vga_b}, {8'd0, exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lo, bl, fs;
    reset  = 1'b1;
    ff_all = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_en", {31'd0, pix_en}, 32'd0);
    chk("rst_hsync", {31'd0, hsync}, 32'd1);
    chk("rst_vsync", {31'd0, vsync}, 32'd1);
    chk("rst_blank", {31'd0, blank_n}, 32'd0);
    chk_rgb("rst_rgb", 24'h000000);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    chk("rst_addr", vga_addr, BASE);

    // Release: pix_en goes 1 first, the counters advance one edge later.
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel1_pix_en", {31'd0, pix_en}, 32'd1);
    chk("rel1_blank", {31'd0, blank_n}, 32'd0);
    chk("rel1_addr", vga_addr, BASE);
    chk("rel1_hsync", {31'd0, hsync}, 32'd1);
    @(posedge clk); #1;
    chk("rel2_pix_en", {31'd0, pix_en}, 32'd0);
    chk("rel2_blank", {31'd0, blank_n}, 32'd1);
    chk("rel2_addr", vga_addr, BASE + 32'd1);
    chk_rgb("rel2_rgb", 24'h000000);
    @(posedge clk); #1;
    chk("rel3_pix_en", {31'd0, pix_en}, 32'd1);
    adv();

    // Marked red pixel at (5,3), then (6,3) holds 6^3 = 8'h05.
    set_hv(10'd5, 10'd3);
    chk("addr_5_3", vga_addr, BASE + 32'h0305);
    adv();
    chk_rgb("rgb_5_3", 24'hFF0000);
    chk("blank_5_3", {31'd0, blank_n}, 32'd1);
    chk("addr_6_3", vga_addr, BASE + 32'h0306);
    adv();
    chk_rgb("rgb_6_3", 24'h002455);

    // Last image pixel, then first pixel right of the image (memory gives FF).
    set_hv(10'd255, 10'd255);
    chk("addr_255_255", vga_addr, BASE + 32'h0000_FFFF);
    adv();
    chk_rgb("rgb_255_255", 24'h00FFFF);
    adv();
    chk_rgb("rgb_256_255", 24'h000000);
    chk("blank_256_255", {31'd0, blank_n}, 32'd1);

    ff_all = 1'b1;
    set_hv(10'd10, 10'd10);
    adv();
    chk_rgb("rgb_10_10_ff", 24'hFFFFFF);
    set_hv(10'd256, 10'd10);
    adv();
    chk_rgb("rgb_256_10", 24'h000000);
    chk("blank_256_10", {31'd0, blank_n}, 32'd1);
    set_hv(10'd10, 10'd300);
    adv();
    chk_rgb("rgb_10_300", 24'h000000);
    chk("blank_10_300", {31'd0, blank_n}, 32'd1);
    ff_all = 1'b0;

    // Active-area edges.
    set_hv(10'd639, 10'd479);
    adv();
    chk("blank_639_479", {31'd0, blank_n}, 32'd1);
    adv();
    chk("blank_640_479", {31'd0, blank_n}, 32'd0);
    set_hv(10'd639, 10'd480);
    adv();
    chk("blank_639_480", {31'd0, blank_n}, 32'd0);

    // hsync edges.
    set_hv(10'd655, 10'd20);
    adv();
    chk("hs_655", {31'd0, hsync}, 32'd1);
    adv();
    chk("hs_656", {31'd0, hsync}, 32'd0);
    set_hv(10'd751, 10'd20);
    adv();
    chk("hs_751", {31'd0, hsync}, 32'd0);
    adv();
    chk("hs_752", {31'd0, hsync}, 32'd1);

    // One full line: 96 sync pixels, 640 active pixels.
    set_hv(10'd0, 10'd20);
    lo = 0;
    bl = 0;
    for (int i = 0; i < 800; i++) begin
      adv();
      if (hsync == 1'b0) lo++;
      if (blank_n == 1'b1) bl++;
    end
    chk("hs_low_count", lo, 32'd96);
    chk("blank_count", bl, 32'd640);
    chk("line_wrap_addr", vga_addr, BASE + 32'h1500);

    // Lines 488..491: vsync low for exactly lines 490 and 491.
    set_hv(10'd0, 10'd488);
    lo = 0;
    fs = 0;
    for (int i = 0; i < 3200; i++) begin
      adv();
      if (vsync == 1'b0) lo++;
      if (frame_start == 1'b1) fs++;
    end
    chk("vs_low_count", lo, 32'd1600);
    chk("vs_fs_count", fs, 32'd0);

    // Frame wrap: frame_start is high for one clk after the (799,524) edge.
    set_hv(10'd798, 10'd524);
    adv();
    chk("fs_798", {31'd0, frame_start}, 32'd0);
    @(posedge clk); #1;
    chk("fs_799_pre", {31'd0, frame_start}, 32'd0);
    @(posedge clk); #1;
    chk("fs_pulse", {31'd0, frame_start}, 32'd1);
    chk("fs_addr", vga_addr, BASE);
    chk("fs_vsync", {31'd0, vsync}, 32'd1);
    @(posedge clk); #1;
    chk("fs_after", {31'd0, frame_start}, 32'd0);
    adv();
    chk("blank_0_0", {31'd0, blank_n}, 32'd1);

    // Mid-frame reset for a single clk.
    set_hv(10'd400, 10'd200);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_pix_en", {31'd0, pix_en}, 32'd0);
    chk("mrst_addr", vga_addr, BASE);
    chk("mrst_hsync", {31'd0, hsync}, 32'd1);
    chk("mrst_vsync", {31'd0, vsync}, 32'd1);
    chk("mrst_blank", {31'd0, blank_n}, 32'd0);
    chk_rgb("mrst_rgb", 24'h000000);
    chk("mrst_fs", {31'd0, frame_start}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mrel1_pix_en", {31'd0, pix_en}, 32'd1);
    chk("mrel1_addr", vga_addr, BASE);
    @(posedge clk); #1;
    chk("mrel2_addr", vga_addr, BASE + 32'd1);
    chk("mrel2_blank", {31'd0, blank_n}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
